// File: rtl/load_use_stall_ctrl.sv
// load_use_stall_ctrl
// Load-use hazard controller for the five-stage pipeline. When the ID-stage
// instruction reads a register that the EX-stage load is about to write, PC and
// IF/ID are held and a bubble is pushed into ID/EX until data memory returns
// the load data. The released dependent instruction then gets a one-cycle
// MEM/WB->EX load-forward select on each operand that matched.
//
// Optional feature: define STALL_PERF_CNT_EN to add the saturating
// stall_cycles[31:0] output, which counts every cycle with pc_stall high.
module load_use_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic                  mem_ready,
    input  logic                  flush,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_bubble,
    output logic                  fwd_load_a,
    output logic                  fwd_load_b,
    output logic                  timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // The counter holds the number of wait cycles already spent; the cycle that
    // would make it reach MAX_WAIT is the last one allowed.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             hit_a_q, hit_a_d;
    logic             hit_b_q, hit_b_d;
    logic             fwd_a_q, fwd_a_d;
    logic             fwd_b_q, fwd_b_d;
    logic             timeout_q, timeout_d;
    logic             stall;
    logic             load_writes;
    logic             match_a;
    logic             match_b;
    logic             hazard;

    // Hazard detection: an EX load writing a non-zero rd that ID actually reads.
    always_comb begin
        load_writes = ex_mem_read && ex_reg_write && (ex_rd != '0);
        match_a     = id_use_rs1 && (ex_rd == id_rs1);
        match_b     = id_use_rs2 && (ex_rd == id_rs2);
        hazard      = load_writes && (match_a || match_b);
    end

    // Next-state and stall logic; flush wins over hazard and mem_ready.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hit_a_d    = hit_a_q;
        hit_b_d    = hit_b_q;
        fwd_a_d    = 1'b0;
        fwd_b_d    = 1'b0;
        timeout_d  = timeout_q;
        stall      = 1'b0;
        if (flush) begin
            state_d    = IDLE;
            wait_cnt_d = '0;
            hit_a_d    = 1'b0;
            hit_b_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, RELEASE: begin
                    if (hazard) begin
                        stall      = 1'b1;
                        hit_a_d    = match_a;
                        hit_b_d    = match_b;
                        wait_cnt_d = '0;
                        state_d    = WAIT_MEM;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (mem_ready) begin
                        fwd_a_d = hit_a_q;
                        fwd_b_d = hit_b_q;
                        state_d = RELEASE;
                    end else begin
                        stall = 1'b1;
                        if (wait_cnt_q == WAIT_LAST) begin
                            timeout_d  = 1'b1;
                            wait_cnt_d = '0;
                            state_d    = IDLE;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Stall outputs are forced low while reset is asserted so a reset in the
    // middle of a stall releases the pipeline immediately.
    always_comb begin
        pc_stall    = stall && !rst;
        ifid_stall  = stall && !rst;
        idex_bubble = stall && !rst;
        fwd_load_a  = fwd_a_q;
        fwd_load_b  = fwd_b_q;
        timeout     = timeout_q;
    end

    // State, operand-hit, forward-select and sticky timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            hit_a_q    <= 1'b0;
            hit_b_q    <= 1'b0;
            fwd_a_q    <= 1'b0;
            fwd_b_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            hit_a_q    <= hit_a_d;
            hit_b_q    <= hit_b_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Performance counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Testbench for load_use_stall_ctrl: directed steps, one per clock cycle.
// Each step drives inputs shortly after the rising edge, pushes the expected
// outputs to a scoreboard queue, and pops/compares them at the falling edge.
module tb_load_use_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       mem_read;
        logic       reg_write;
        logic       mem_ready;
        logic       flush;
    } stim_t;

    typedef struct {
        string      tag;
        logic [5:0] outs;
    } expect_t;

    // Expected output vector: {pc_stall, ifid_stall, idex_bubble, fwd_a, fwd_b, timeout}
    localparam logic [5:0] E_NONE  = 6'b000_000;
    localparam logic [5:0] E_STALL = 6'b111_000;
    localparam logic [5:0] E_FA    = 6'b000_100;
    localparam logic [5:0] E_FB    = 6'b000_010;
    localparam logic [5:0] E_TO    = 6'b000_001;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_reg_write;
    logic       mem_ready;
    logic       flush;
    logic       pc_stall;
    logic       ifid_stall;
    logic       idex_bubble;
    logic       fwd_load_a;
    logic       fwd_load_b;
    logic       timeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    expect_t scoreboard[$];
    int      tests_run;
    int      fail_count;

    load_use_stall_ctrl #(
        .REG_ADDR_W (5),
        .MAX_WAIT   (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .mem_ready    (mem_ready),
        .flush        (flush),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .idex_bubble  (idex_bubble),
        .fwd_load_a   (fwd_load_a),
        .fwd_load_b   (fwd_load_b),
        .timeout      (timeout)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t haz_s(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic use1,
                                    input logic use2);
        stim_t s;
        s           = '0;
        s.rd        = rd;
        s.rs1       = rs1;
        s.rs2       = rs2;
        s.use1      = use1;
        s.use2      = use2;
        s.mem_read  = 1'b1;
        s.reg_write = 1'b1;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s, input string tag, input logic [5:0] e);
        expect_t x;
        rst          = s.rst;
        id_rs1       = s.rs1;
        id_rs2       = s.rs2;
        id_use_rs1   = s.use1;
        id_use_rs2   = s.use2;
        ex_rd        = s.rd;
        ex_mem_read  = s.mem_read;
        ex_reg_write = s.reg_write;
        mem_ready    = s.mem_ready;
        flush        = s.flush;
        x.tag        = tag;
        x.outs       = e;
        scoreboard.push_back(x);
    endtask

    task automatic checkOutput();
        expect_t    x;
        logic [5:0] obs;
        obs = {pc_stall, ifid_stall, idex_bubble, fwd_load_a, fwd_load_b, timeout};
        tests_run++;
        if (scoreboard.size() == 0) begin
            fail_count++;
            $error("[TB] FAIL scoreboard_empty observed=%b expected=entry", obs);
        end else begin
            x = scoreboard.pop_front();
            assert (obs === x.outs) else begin
                fail_count++;
                $error("[TB] FAIL %s observed=%b expected=%b", x.tag, obs, x.outs);
            end
        end
    endtask

`ifdef STALL_PERF_CNT_EN
    task automatic checkPerf(input string tag, input logic [31:0] e);
        tests_run++;
        assert (stall_cycles === e) else begin
            fail_count++;
            $error("[TB] FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, e);
        end
    endtask
`endif

    task automatic step(input string tag, input stim_t s, input logic [5:0] e);
        @(posedge clk);
        #1;
        applyStimulus(s, tag, e);
        @(negedge clk);
        checkOutput();
    endtask

    // Directed sequence of hazard scenarios.
    initial begin
        stim_t s;
        tests_run    = 0;
        fail_count   = 0;
        rst          = 1'b1;
        id_rs1       = '0;
        id_rs2       = '0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        ex_rd        = '0;
        ex_mem_read  = 1'b0;
        ex_reg_write = 1'b0;
        mem_ready    = 1'b0;
        flush        = 1'b0;

        s = idle_s(); s.rst = 1'b1;
        step("reset_hold", s, E_NONE);
        step("idle", idle_s(), E_NONE);
`ifdef STALL_PERF_CNT_EN
        checkPerf("perf_reset", 32'd0);
`endif

        // Single-cycle stall, rs1 forward
        step("t1_hazard", haz_s(5'd5, 5'd5, 5'd0, 1'b1, 1'b0), E_STALL);
        s = idle_s(); s.mem_ready = 1'b1;
        step("t1_mem_ready", s, E_NONE);
        step("t1_release", idle_s(), E_FA);
        step("t1_after", idle_s(), E_NONE);
`ifdef STALL_PERF_CNT_EN
        checkPerf("perf_t1", 32'd1);
`endif
        s = idle_s(); s.rst = 1'b1;
        step("rst_pulse", s, E_NONE);
`ifdef STALL_PERF_CNT_EN
        checkPerf("perf_after_rst", 32'd0);
`endif
        step("rst_release", idle_s(), E_NONE);

        // Four stall cycles, both operands forward
        step("t2_hazard", haz_s(5'd7, 5'd7, 5'd7, 1'b1, 1'b1), E_STALL);
        for (int i = 0; i < 3; i++) begin
            step("t2_wait", idle_s(), E_STALL);
        end
        s = idle_s(); s.mem_ready = 1'b1;
        step("t2_mem_ready", s, E_NONE);
        step("t2_release", idle_s(), E_FA | E_FB);
        step("t2_after", idle_s(), E_NONE);
`ifdef STALL_PERF_CNT_EN
        checkPerf("perf_t2", 32'd4);
`endif

        // Cases that must not stall
        step("neg_rd_x0", haz_s(5'd0, 5'd0, 5'd0, 1'b1, 1'b1), E_NONE);
        s = haz_s(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); s.reg_write = 1'b0;
        step("neg_no_reg_write", s, E_NONE);
        step("neg_rs2_unused", haz_s(5'd9, 5'd0, 5'd9, 1'b1, 1'b0), E_NONE);
        s = haz_s(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); s.mem_read = 1'b0;
        step("neg_not_load", s, E_NONE);

        // rs2-only match, then a new hazard arriving in RELEASE
        step("b_hazard", haz_s(5'd9, 5'd1, 5'd9, 1'b0, 1'b1), E_STALL);
        s = idle_s(); s.mem_ready = 1'b1;
        step("b_mem_ready", s, E_NONE);
        step("b_release_hazard", haz_s(5'd4, 5'd4, 5'd0, 1'b1, 1'b0), E_FB | E_STALL);
        s = idle_s(); s.mem_ready = 1'b1;
        step("b2_mem_ready", s, E_NONE);
        step("b2_release", idle_s(), E_FA);
        step("b2_after", idle_s(), E_NONE);

        // Flush during WAIT_MEM beats mem_ready
        step("fl_hazard", haz_s(5'd6, 5'd6, 5'd0, 1'b1, 1'b0), E_STALL);
        step("fl_wait", idle_s(), E_STALL);
        s = idle_s(); s.flush = 1'b1; s.mem_ready = 1'b1;
        step("fl_flush", s, E_NONE);
        step("fl_no_fwd", idle_s(), E_NONE);

        // Flush beats a hazard in IDLE
        s = haz_s(5'd6, 5'd6, 5'd0, 1'b1, 1'b0); s.flush = 1'b1;
        step("fl_idle_hazard", s, E_NONE);
        s = idle_s(); s.mem_ready = 1'b1;
        step("fl_idle_next", s, E_NONE);
        step("fl_idle_after", idle_s(), E_NONE);

        // Reset in the middle of a stall
        step("rs_hazard", haz_s(5'd8, 5'd8, 5'd0, 1'b1, 1'b0), E_STALL);
        step("rs_wait", idle_s(), E_STALL);
        s = haz_s(5'd8, 5'd8, 5'd0, 1'b1, 1'b0); s.rst = 1'b1;
        step("rs_mid_stall", s, E_NONE);
`ifdef STALL_PERF_CNT_EN
        checkPerf("perf_mid_rst", 32'd0);
`endif
        step("rs_release", idle_s(), E_NONE);

        // Memory timeout after 15 wait cycles; timeout stays set
        step("to_hazard", haz_s(5'd10, 5'd10, 5'd0, 1'b1, 1'b0), E_STALL);
        for (int i = 0; i < 15; i++) begin
            step("to_wait", idle_s(), E_STALL);
        end
        step("to_idle", idle_s(), E_TO);
        s = idle_s(); s.mem_ready = 1'b1;
        step("to_no_fwd", s, E_TO);
        step("to_hazard2", haz_s(5'd11, 5'd11, 5'd0, 1'b1, 1'b0), E_STALL | E_TO);
        s = idle_s(); s.mem_ready = 1'b1;
        step("to_mem_ready2", s, E_TO);
        step("to_release2", idle_s(), E_FA | E_TO);
        s = idle_s(); s.rst = 1'b1;
        step("to_rst", s, E_NONE);
        step("to_cleared", idle_s(), E_NONE);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
